// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin N-master to 1-slave bus arbiter with optional lock
module bus_arbiter #(
    parameter int N_MASTERS    = 2,
    parameter int XLEN         = 32,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_MASTERS-1:0]          i_m_bus_en,
    input  logic [N_MASTERS-1:0]          i_m_wr_en,
    input  logic [N_MASTERS*XLEN-1:0]     i_m_addr,
    input  logic [N_MASTERS*XLEN-1:0]     i_m_wr_data,
    input  logic [N_MASTERS*XLEN/8-1:0]   i_m_byte_en,
    input  logic [N_MASTERS-1:0]          i_m_lock,
    output logic [N_MASTERS-1:0]          o_m_ack,
    output logic [XLEN-1:0]               o_m_rd_data,
    output logic                          o_s_bus_en,
    output logic                          o_s_wr_en,
    output logic [XLEN-1:0]               o_s_addr,
    output logic [XLEN-1:0]               o_s_wr_data,
    output logic [XLEN/8-1:0]             o_s_byte_en,
    input  logic                          i_s_ack,
    input  logic [XLEN-1:0]               i_s_rd_data,
    output logic [N_MASTERS-1:0]          o_grant
);
    localparam int IDX_W = $clog2(N_MASTERS);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int BE_W  = XLEN / 8;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_LOCKED} state_t;

    state_t               state, state_n;
    logic [N_MASTERS-1:0] grant, grant_n;
    logic [IDX_W-1:0]     owner, owner_n;
    logic [IDX_W-1:0]     last_grant, last_grant_n;
    logic [CNT_W-1:0]     lock_cnt, lock_cnt_n;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     cand_idx;
    int                   cand;

    // First requester at or after last_grant+1, wrapping modulo N_MASTERS.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            cand     = int'((32'(last_grant) + 32'(1) + 32'(i)) % 32'(N_MASTERS));
            cand_idx = IDX_W'(cand);
            if (!pick_valid && i_m_bus_en[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            grant      <= '0;
            owner      <= '0;
            last_grant <= IDX_W'(N_MASTERS - 1);
            lock_cnt   <= '0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            lock_cnt   <= lock_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        owner_n      = owner;
        last_grant_n = last_grant;
        lock_cnt_n   = lock_cnt;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    state_n           = S_BUSY;
                    owner_n           = pick_idx;
                    grant_n           = '0;
                    grant_n[pick_idx] = 1'b1;
                end
            end
            S_BUSY: begin
                if (i_s_ack) begin
                    last_grant_n = owner;
                    if (i_m_lock[owner]) begin
                        state_n    = S_LOCKED;
                        lock_cnt_n = '0;
                    end else begin
                        state_n = S_IDLE;
                        grant_n = '0;
                    end
                end
            end
            S_LOCKED: begin
                // The owner keeps the bus for LOCK_TIMEOUT idle cycles, then releases it.
                if (i_m_bus_en[owner]) begin
                    state_n = S_BUSY;
                end else if (lock_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_n    = S_IDLE;
                    grant_n    = '0;
                    lock_cnt_n = '0;
                end else begin
                    lock_cnt_n = lock_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_comb begin
        o_s_bus_en  = 1'b0;
        o_s_wr_en   = 1'b0;
        o_s_addr    = '0;
        o_s_wr_data = '0;
        o_s_byte_en = '0;
        if (state == S_BUSY) begin
            o_s_bus_en = 1'b1;
            for (int k = 0; k < N_MASTERS; k++) begin
                if (owner == IDX_W'(k)) begin
                    o_s_wr_en   = i_m_wr_en[k];
                    o_s_addr    = i_m_addr[k*XLEN +: XLEN];
                    o_s_wr_data = i_m_wr_data[k*XLEN +: XLEN];
                    o_s_byte_en = i_m_byte_en[k*BE_W +: BE_W];
                end
            end
        end
    end

    assign o_m_ack     = (state == S_BUSY && i_s_ack) ? grant : '0;
    assign o_m_rd_data = i_s_rd_data;
    assign o_grant     = grant;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- N-master to 1-slave arbiter for the multi-core build.
- Sits directly downstream of each core's bus master port (bus_en/wr_en/addr/wr_data/byte_en out, ack/rd_data in) and drives one shared memory/peripheral bus.
- Round-robin grant, one transaction per grant.
- Optional lock so a hart can keep the bus for an atomic sequence (e.g. LR/SC or AMO read-modify-write).

Parameters:
- N_MASTERS, 2, number of requesting masters (2..8).
- XLEN, 32, address/data width.
- LOCK_TIMEOUT, 16, max idle cycles a lock is held for its owner before the lock is released.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_m_bus_en  in  N_MASTERS  request per master.
- i_m_wr_en  in  N_MASTERS  write (1) / read (0) per master.
- i_m_addr  in  N_MASTERS*XLEN  address; master k at bits [k*XLEN +: XLEN].
- i_m_wr_data  in  N_MASTERS*XLEN  write data, packed the same way.
- i_m_byte_en  in  N_MASTERS*(XLEN/8)  byte enables.
- i_m_lock  in  N_MASTERS  request to retain the bus after this transaction.
- o_m_ack  out  N_MASTERS  one-cycle completion pulse to the granted master.
- o_m_rd_data  out  XLEN  read data, shared by all masters; valid only with that master's ack.
- o_s_bus_en  out  1  slave request.
- o_s_wr_en  out  1  slave write enable.
- o_s_addr  out  XLEN  slave address.
- o_s_wr_data  out  XLEN  slave write data.
- o_s_byte_en  out  XLEN/8  slave byte enables.
- i_s_ack  in  1  slave completion pulse.
- i_s_rd_data  in  XLEN  slave read data, valid with i_s_ack.
- o_grant  out  N_MASTERS  registered one-hot current owner; 0 when idle.

Behaviour:
- Bus protocol, both sides:
  - Requester holds bus_en and all qualifiers stable until the ack cycle. Ack is a single-cycle pulse.
  - The requester may keep bus_en high in the cycle after ack; that is a new request.
- States: IDLE, BUSY, LOCKED.
- IDLE:
  - If any i_m_bus_en is set, grant the first requester at or after (last_grant+1) mod N_MASTERS.
  - At the next edge: register o_grant, go to BUSY.
  - No requests: stay in IDLE. o_grant = 0.
- BUSY:
  - o_s_bus_en = 1. o_s_* are muxed combinationally from the granted master's live inputs.
  - o_m_rd_data = i_s_rd_data (passthrough in all states).
  - o_m_ack[g] = i_s_ack. Other ack bits stay 0.
  - On i_s_ack, record last_grant = g, then:
    - if i_m_lock[g] is 1 in the ack cycle: go to LOCKED, clear lock counter;
    - otherwise: go to IDLE, o_grant = 0.
- LOCKED:
  - o_s_bus_en = 0. o_grant stays at the owner.
  - If owner bus_en = 1: go to BUSY with the same grant at the next edge. Other requesters are ignored.
  - Otherwise increment the lock counter. At LOCK_TIMEOUT go to IDLE and return to normal round-robin.
- Latency:
  - Request seen in cycle t gives o_s_bus_en at t+1.
  - Slave ack at cycle u reaches the master combinationally at u.
  - One bubble cycle (IDLE or LOCKED) always separates consecutive slave transactions.
- Slave outputs when not BUSY: bus_en, wr_en, addr, wr_data, byte_en all 0.
- i_s_ack outside BUSY is ignored; no master ack is generated.
- A master dropping bus_en while BUSY (protocol violation): the transaction still completes on i_s_ack, and the ack is still pulsed to that master.
- Reset (any state, including mid-transaction): go to IDLE, o_grant = 0, all o_m_ack = 0, lock counter = 0, last_grant = N_MASTERS-1 so master 0 has first priority. The slave must be reset in the same cycle.
- No combinational path from i_m_bus_en to o_s_bus_en.

Test Plan:
- Single read: master 1 raises bus_en, addr=0x8000_0010. o_s_bus_en rises the next cycle with that addr. Slave acks 2 cycles later with rd_data=0xDEAD_BEEF. o_m_ack=2'b10 for 1 cycle, o_m_rd_data=0xDEAD_BEEF. o_grant returns to 0 the next cycle.
- Simultaneous requests after reset: both masters request; grant order is 0,1,0,1 across 4 back-to-back transactions. Each grant is separated by exactly 1 bubble cycle.
- Write path: master 0 writes addr=0x1000, wr_data=0x1234_5678, byte_en=4'b0011. Slave sees the identical values and wr_en=1. Master 1's inputs never appear on o_s_*.
- Lock: master 0 asserts lock in its ack cycle, master 1 is requesting. Master 0 re-requests 3 cycles later and is granted before master 1. Variant: master 0 never re-requests; master 1 is granted after exactly LOCK_TIMEOUT=16 cycles.
- Reset mid-transaction: i_rst is asserted while BUSY, before slave ack. Next cycle: o_s_bus_en=0, o_grant=0, o_m_ack=0. A stray i_s_ack afterwards produces no master ack.
- Spurious ack: i_s_ack pulses while IDLE -> o_m_ack stays 0 and the state stays IDLE.
